fastinput_counter: RTL
======================

# fastinput_counter

Parametrised successor to the fixed 4-channel fast-input counter. Each channel synchronises an asynchronous fast input, applies a programmable digital glitch filter, and counts the selected edges in a saturating counter. A snapshot register and a per-channel clear allow software to read and clear counts atomically. Sits between the board's fast digital inputs and the register/bus layer.

## Interface
- CH, 4, number of input channels (1..32)
- CW, 32, counter width in bits (8..32)
- SYNC_STAGES, 2, synchroniser depth (2..4)
- FILT_W, 4, width of the filter-length setting
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- fast  in  CH  asynchronous fast inputs, bit i = channel i
- edge_mode  in  2*CH  per channel, bits [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both
- filt_len  in  FILT_W  stability requirement in clocks, shared by all channels
- clr  in  CH  per-channel clear pulse, clears counter and overflow
- latch  in  1  snapshot pulse, copies all counters into snapshot registers
- cnt  out  CH*CW  live counters, channel i at [CW*i+CW-1:CW*i]
- snap  out  CH*CW  snapshot registers, same packing
- ovf  out  CH  sticky saturation flag per channel
- edge_pulse  out  CH  one-clock pulse per counted edge

## Operation
- Synchroniser: SYNC_STAGES flops per channel. The final stage is s[i].
- Filter: per channel, a stable-state register f[i] and a FILT_W-bit run counter r[i].
  - When s[i]==f[i], r[i] is set to 0.
  - When s[i]!=f[i] and r[i]==filt_len, f[i] takes s[i] and r[i] is set to 0.
  - Otherwise r[i] increments.
  - With filt_len=0, f follows s with one clock of delay. Any pulse on s shorter than filt_len+1 clocks is rejected.
- Edge event: occurs on the clock at which f[i] changes. It is qualified when the direction (0→1 rising, 1→0 falling) is enabled by edge_mode[i].
- Counter, per channel, in priority order:
  - clr[i]: counter ← 0 and ovf[i] ← 0. Any coincident edge is discarded.
  - Qualified edge with counter == 2^CW−1: counter holds and ovf[i] ← 1.
  - Qualified edge otherwise: counter increments.
- edge_pulse[i] is registered. It is high for the single clock following each qualified edge, including edges discarded by clr and edges at saturation.
- Snapshot: on latch, every snap channel ← its counter value before this clock's update. latch together with clr[i] gives an atomic read-and-clear: snap holds the old value and the counter becomes 0.
- Changes to edge_mode and filt_len take effect on the next clock. A filter run in progress is compared against the new filt_len; if r[i] > new filt_len, the update happens on the next clock where s!=f.

## Timing
- Reset (rst=0, asynchronous): synchroniser flops, f, r, cnt, snap, ovf and edge_pulse all go to 0.
  - Because f resets to 0, an input held high through reset release counts as one rising edge.
- Latency: fast sampled at edge e → s valid at edge e+SYNC_STAGES−1 → f and cnt update at edge e+SYNC_STAGES+filt_len → edge_pulse high through the following cycle.
  - Defaults with filt_len=0: cnt changes 2 clocks after the sampling edge.
- Minimum countable pulse width: filt_len+1 clocks (high or low). The maximum countable rate is one edge per filt_len+1 clocks.
- Reset asserted mid-count clears all state immediately. The first qualified edge after release counts from 0.
- clr or latch held high for several cycles acts on every cycle.

## Test plan
- Defaults (clk 20 ns), filt_len=0, edge_mode ch0=01: release reset, toggle fast[0] with a 100 ns half-period for 4 high pulses. Required: cnt ch0=4, other channels 0, 4 edge_pulse[0] pulses.
- Same stimulus with ch0 edge_mode=11 (both edges). Required: cnt ch0=8. With 10 (falling): cnt ch0=4, falling edges only. With 00: cnt ch0=0.
- filt_len=3, pulses on fast[1] of widths 2, 3, 4 and 5 clocks, edge_mode=01. Required: only the 4- and 5-clock pulses count, cnt ch1=2.
- CW=8: drive 256 rising edges on ch2. Required: cnt ch2=255, ovf[2]=1. Then pulse clr[2]: cnt=0 and ovf=0 on the next clock.
- Count 7 on ch3, then pulse latch and clr[3] in the same cycle, coincident with a qualified edge. Required: snap ch3=7, cnt ch3=0, edge_pulse[3] high once.
- Assert rst mid-stream with cnt ch0=5. Required: all outputs 0 asynchronously. If fast[0] is held high at release, cnt ch0=1 after SYNC_STAGES+filt_len clocks.

Source files
------------

// File: rtl/fastinput_counter.sv
// Multi-channel fast-input edge counter: synchroniser, digital glitch filter,
// selectable edge qualification, saturating counters with snapshot and clear.
module fastinput_counter #(
    parameter int CH          = 4,
    parameter int CW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        fast,
    input  logic [2*CH-1:0]      edge_mode,
    input  logic [FILT_W-1:0]    filt_len,
    input  logic [CH-1:0]        clr,
    input  logic                 latch,
    output logic [CH*CW-1:0]     cnt,
    output logic [CH*CW-1:0]     snap,
    output logic [CH-1:0]        ovf,
    output logic [CH-1:0]        edge_pulse
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   f;
        logic                   f_next;
        logic [FILT_W-1:0]      r;
        logic [FILT_W-1:0]      r_next;
        logic                   rise;
        logic                   fall;
        logic                   qual;
        logic [CW-1:0]          count;
        logic [CW-1:0]          snap_q;
        logic                   ovf_q;
        logic                   pulse_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], fast[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // >= rather than == so a run that overshot a freshly lowered filt_len
        // still resolves on the next clock where s differs from f
        always_comb begin
            f_next = f;
            r_next = '0;
            if (s != f) begin
                if (r >= filt_len) begin
                    f_next = s;
                end else begin
                    r_next = r + FILT_W'(1);
                end
            end
        end

        assign rise = f_next & ~f;
        assign fall = ~f_next & f;
        assign qual = (rise & edge_mode[2*i]) | (fall & edge_mode[2*i+1]);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                f <= 1'b0;
                r <= '0;
            end else begin
                f <= f_next;
                r <= r_next;
            end
        end

        // Clear wins over a coincident edge; the edge still produces a pulse
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                count   <= '0;
                ovf_q   <= 1'b0;
                snap_q  <= '0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= qual;
                if (latch) begin
                    snap_q <= count;
                end
                if (clr[i]) begin
                    count <= '0;
                    ovf_q <= 1'b0;
                end else if (qual) begin
                    if (count == CNT_MAX) begin
                        ovf_q <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
            end
        end

        assign cnt[CW*i +: CW]  = count;
        assign snap[CW*i +: CW] = snap_q;
        assign ovf[i]           = ovf_q;
        assign edge_pulse[i]    = pulse_q;
    end

endmodule
